alu_sched: RTL and testbench
============================

# alu_sched

Round-robin scheduler that shares the single combinational 8-bit ALU among `NREQ` requesters. Each requester issues one operation (operands `a`, `b` and a 6-bit opcode) through a valid/ready handshake. The scheduler holds the ALU inputs stable for a per-opcode number of cycles so the long multiply and divide paths settle. It then registers the result and returns it to the owning requester through a response handshake. It sits between the microprocessor's execute-stage clients and the ALU instance.

## Interface
- `NREQ`, default 2: number of requesters (2..8).
- `MUL_CYC`, default 2: EXEC cycles for opcode 000010 (mul).
- `DIV_CYC`, default 4: EXEC cycles for opcode 000011 (div).
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_ready` out NREQ: one-hot grant. Combinational, asserted only in IDLE.
- `req_a`, `req_b` in NREQ*8: operands. Requester i uses bits [8i+7:8i].
- `req_op` in NREQ*6: opcodes. Requester i uses bits [6i+5:6i].
- `rsp_valid` out NREQ: one-hot response valid for the owning requester.
- `rsp_ready` in NREQ: response accepted, one bit per requester.
- `rsp_data` out 8: registered ALU result.
- `rsp_err` out 1: opcode not in the legal set, qualified by `rsp_valid`.
- `alu_a`, `alu_b` out 8: operands driven to the ALU.
- `alu_op` out 6: opcode driven to the ALU.
- `alu_result` in 8: ALU output.

## Operation
- The state machine has three states: IDLE, EXEC and RESP.
- **IDLE:** if any `req_valid` is high, the round-robin arbiter picks a winner, starting the search at `ptr`.
  - `req_ready[winner]` is asserted in the same cycle.
  - The winner's a/b/op are latched into `alu_a`/`alu_b`/`alu_op`, and `owner` is latched.
  - The latency counter is loaded with L−1.
  - `ptr` becomes (winner+1) mod NREQ.
  - Next state is EXEC.
- **Latency L per opcode:**
  - 000000 add, 000001 sub, 000100 cmp, 001000 not, 001001 and, 001010 or, 001011 xor: L = 1.
  - 000010 mul: L = `MUL_CYC`.
  - 000011 div: L = `DIV_CYC`.
  - Any other opcode: L = 1, and `err` is latched as 1.
- **EXEC:** the counter decrements each cycle. When it is 0:
  - `alu_result` is registered into `rsp_data`.
  - `rsp_valid[owner]` is set.
  - Next state is RESP.
  - Compare results use bits [1:0]; the ALU zero-extends them and the scheduler passes them through unchanged. Mul and div results are the ALU's 8-bit outputs.
- **RESP:** `rsp_valid[owner]`, `rsp_data` and `rsp_err` are held until `rsp_ready[owner]` is high. Then `rsp_valid` clears and next state is IDLE.
  - `rsp_ready` bits of non-owners are ignored.
- `alu_a`/`alu_b`/`alu_op` hold their last latched value outside EXEC, so the ALU inputs do not toggle.
- Requests are never dropped. A requester that keeps `req_valid` high is granted within NREQ transactions.

## Timing
- **Reset values (asynchronous):** state = IDLE, `ptr` = 0, `owner` = 0, counter = 0, and the following outputs are all 0: `req_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, `alu_a`, `alu_b`, `alu_op`.
- **Grant-to-response latency:** with the grant (handshake) in cycle T, EXEC occupies T+1..T+L and `rsp_valid` is first high in T+L+1.
- Minimum issue interval per transaction is L+2 cycles: grant, L EXEC cycles, one RESP cycle with immediate `rsp_ready`. There is one IDLE cycle between transactions; no back-to-back grant is made from RESP.
- Simultaneous `req_valid` from several requesters: the winner is the lowest index at or after `ptr`, wrapping modulo NREQ.
- `req_valid` dropping in IDLE before the grant is legal: no grant is made and no state changes.
- `rsp_ready` asserted in the same cycle `rsp_valid` rises completes the response. The next IDLE follows in the following cycle.
- Reset asserted mid-EXEC or mid-RESP aborts the operation. The response is lost, and outputs return to reset values immediately.
- `MUL_CYC` or `DIV_CYC` = 1 is legal and behaves as L = 1.

## Structure
- Package `alu_sched_pkg` holds:
  - opcode localparams (`OP_ADD`..`OP_XOR`),
  - the state enum (`S_IDLE`, `S_EXEC`, `S_RESP`),
  - a function `op_latency(op, mul_cyc, div_cyc)` returning L and a function `op_legal(op)`.
- Sub-module `rr_arbiter`, parameterized by N:
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and encoded index.
  - It is purely combinational; `ptr` is stored in `alu_sched`.
- The ALU itself is instantiated outside; `alu_sched` only connects to its ports.

## Test plan
- **Add, single requester:** req0 issues a=100, b=27, op=000000.
  - `req_ready[0]` is high in T.
  - `rsp_valid[0]` is high in T+2 with `rsp_data`=127 and `rsp_err`=0.
- **Divide latency:** req1 issues a=200, b=7, op=000011 with DIV_CYC=4.
  - `rsp_valid[1]` rises exactly at T+5 with `rsp_data`=28.
  - `alu_a`/`alu_b` are stable over T+1..T+4.
- **Round-robin fairness:** both requesters hold `req_valid` for 4 transactions from reset. Grant order is 0,1,0,1.
- **Backpressure:** `rsp_ready[0]` is held low for 5 cycles while req1 is pending.
  - `rsp_data` is held and `req_ready` stays 0.
  - req1 is granted 1 cycle after `rsp_ready[0]` rises.
- **Illegal opcode:** op=010000 with a=5, b=3. Response has `rsp_data`=0 and `rsp_err`=1 at T+2.
- **Reset mid-operation:** `rst_n` is pulled low during cycle 2 of a mul with MUL_CYC=3.
  - All outputs are 0 immediately.
  - After release, a new add a=1, b=1 returns 2 and is granted from `ptr`=0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
`default_nettype none
// alu_sched_pkg -- opcodes, FSM state type and latency/legality helpers for alu_sched.
// Rev 1.0
package alu_sched_pkg;

   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_SUB = 6'b000001;
   localparam logic [5:0] OP_MUL = 6'b000010;
   localparam logic [5:0] OP_DIV = 6'b000011;
   localparam logic [5:0] OP_CMP = 6'b000100;
   localparam logic [5:0] OP_NOT = 6'b001000;
   localparam logic [5:0] OP_AND = 6'b001001;
   localparam logic [5:0] OP_OR  = 6'b001010;
   localparam logic [5:0] OP_XOR = 6'b001011;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // A zero cycle count would underflow the down-counter, so it is clamped to 1.
   function automatic int unsigned op_latency(input logic [5:0] op,
                                              input int unsigned mul_cyc,
                                              input int unsigned div_cyc);
      int unsigned lat;
      case (op)
         OP_MUL:  lat = mul_cyc;
         OP_DIV:  lat = div_cyc;
         default: lat = 1;
      endcase
      if (lat == 0) lat = 1;
      return lat;
   endfunction

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP,
         OP_NOT, OP_AND, OP_OR, OP_XOR: return 1'b1;
         default:                       return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sched_rr_arbiter.sv
`default_nettype none
// rr_arbiter -- combinational round-robin pick: lowest requester at or after ptr, wrapping.
// Rev 1.0
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   logic [N-1:0] rot;
   logic         found;

   always_comb begin
      // rot[k] is the request k positions after ptr.
      rot   = N'({req, req} >> ptr);
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (en && !found && rot[k]) begin
            found = 1'b1;
            idx   = IW'((int'(ptr) + k) % N);
         end
      end
      if (found) grant = N'(1) << idx;
   end

endmodule
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// alu_sched -- round-robin sharing of one combinational 8-bit ALU among NREQ requesters.
// Rev 1.0
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int MUL_CYC = 2,
   parameter int DIV_CYC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_a,
   input  logic [NREQ*8-1:0] req_b,
   input  logic [NREQ*6-1:0] req_op,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [7:0]        rsp_data,
   output logic              rsp_err,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [5:0]        alu_op,
   input  logic [7:0]        alu_result
);

   localparam int IW = $clog2(NREQ);

   state_t           state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    owner;
   logic [IW-1:0]    win_idx;
   logic [CNT_W-1:0] cnt;
   logic             err;
   logic [NREQ-1:0]  grant;
   logic             arb_en;

   logic [7:0] a_arr  [NREQ];
   logic [7:0] b_arr  [NREQ];
   logic [5:0] op_arr [NREQ];

   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_unpack
         assign a_arr[i]  = req_a[8*i +: 8];
         assign b_arr[i]  = req_b[8*i +: 8];
         assign op_arr[i] = req_op[6*i +: 6];
      end
   endgenerate

   // Grants are suppressed while reset is held so req_ready reads 0 immediately.
   assign arb_en = rst_n && (state == S_IDLE);

   rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .en    (arb_en),
      .grant (grant),
      .idx   (win_idx)
   );

   assign req_ready = grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ptr       <= '0;
         owner     <= '0;
         cnt       <= '0;
         err       <= 1'b0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|grant) begin
                  alu_a  <= a_arr[win_idx];
                  alu_b  <= b_arr[win_idx];
                  alu_op <= op_arr[win_idx];
                  owner  <= win_idx;
                  err    <= !op_legal(op_arr[win_idx]);
                  cnt    <= CNT_W'(op_latency(op_arr[win_idx], MUL_CYC, DIV_CYC) - 1);
                  ptr    <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cnt == '0) begin
                  rsp_data  <= alu_result;
                  rsp_err   <= err;
                  rsp_valid <= NREQ'(1) << owner;
                  state     <= S_RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready[owner]) begin
                  rsp_valid <= '0;
                  rsp_err   <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// tb_alu_sched -- randomized self-checking bench for alu_sched against a transaction-level model.
// Rev 1.0
module tb_alu_sched;

   localparam int N    = 2;
   localparam int MULC = 3;
   localparam int DIVC = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*8-1:0] req_a;
   logic [N*8-1:0] req_b;
   logic [N*6-1:0] req_op;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready;
   logic [7:0]     rsp_data;
   logic           rsp_err;
   logic [7:0]     alu_a;
   logic [7:0]     alu_b;
   logic [5:0]     alu_op;
   logic [7:0]     alu_result;

   logic [7:0] a_v  [N];
   logic [7:0] b_v  [N];
   logic [5:0] op_v [N];
   int         mptr;
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [1:0] g;

   alu_sched #(.NREQ(N), .MUL_CYC(MULC), .DIV_CYC(DIVC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result)
   );

   always #5 clk = ~clk;

   // External ALU: zero-extended compare, divide by zero gives all ones, unknown ops give 0.
   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      case (op)
         6'd0:    return a + b;
         6'd1:    return a - b;
         6'd2:    return 8'((16'(a) * 16'(b)));
         6'd3:    return (b == 8'd0) ? 8'hFF : a / b;
         6'd4:    return {6'b0, (a > b), (a == b)};
         6'd8:    return ~a;
         6'd9:    return a & b;
         6'd10:   return a | b;
         6'd11:   return a ^ b;
         default: return 8'd0;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_a, alu_b, alu_op);

   function automatic int ref_lat(input logic [5:0] op);
      if (op == 6'd2) return MULC;
      if (op == 6'd3) return DIVC;
      return 1;
   endfunction

   function automatic logic ref_illegal(input logic [5:0] op);
      return !(op inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd8, 6'd9, 6'd10, 6'd11});
   endfunction

   function automatic int pick(input logic [1:0] m);
      for (int k = 0; k < N; k++) begin
         if (m[(mptr + k) % N]) return (mptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [5:0] rand_op();
      logic [5:0] tbl [9];
      int r;
      tbl = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd8, 6'd9, 6'd10, 6'd11};
      r = int'($urandom_range(0, 11));
      if (r < 9) return tbl[r];
      return 6'($urandom_range(12, 63));
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive_ops();
      req_a  = {a_v[1], a_v[0]};
      req_b  = {b_v[1], b_v[0]};
      req_op = {op_v[1], op_v[0]};
   endtask

   // Starts at a negedge inside an IDLE cycle; returns at the negedge of the next IDLE cycle.
   task automatic do_round(input logic [1:0] mask, input int d, input bit keep, output logic [1:0] got_grant);
      int w, lat;
      logic [7:0] ea, eb, er;
      logic [5:0] eo;
      logic ee;
      req_valid = mask;
      drive_ops();
      #1;
      got_grant = req_ready;
      w = pick(mask);
      check("grant", 32'(req_ready), 32'(1) << w);
      ea  = a_v[w];
      eb  = b_v[w];
      eo  = op_v[w];
      lat = ref_lat(eo);
      er  = alu_fn(ea, eb, eo);
      ee  = ref_illegal(eo);
      mptr = (w + 1) % N;
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         if (!keep) req_valid[w] = 1'b0;
         check("exec_rsp_valid", 32'(rsp_valid), 32'(0));
         check("exec_req_ready", 32'(req_ready), 32'(0));
         check("alu_a_hold", 32'(alu_a), 32'(ea));
         check("alu_b_hold", 32'(alu_b), 32'(eb));
         check("alu_op_hold", 32'(alu_op), 32'(eo));
      end
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'(1) << w);
      check("rsp_data", 32'(rsp_data), 32'(er));
      check("rsp_err", 32'(rsp_err), 32'(ee));
      for (int c = 0; c < d; c++) begin
         rsp_ready    = '1;
         rsp_ready[w] = 1'b0;
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 32'(1) << w);
         check("bp_rsp_data", 32'(rsp_data), 32'(er));
         check("bp_req_ready", 32'(req_ready), 32'(0));
      end
      rsp_ready    = '0;
      rsp_ready[w] = 1'b1;
      @(negedge clk);
      rsp_ready = '0;
      check("rsp_clear", 32'(rsp_valid), 32'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
      check({tag, "_rsp_data"},  32'(rsp_data),  32'(0));
      check({tag, "_rsp_err"},   32'(rsp_err),   32'(0));
      check({tag, "_alu_a"},     32'(alu_a),     32'(0));
      check({tag, "_alu_b"},     32'(alu_b),     32'(0));
      check({tag, "_alu_op"},    32'(alu_op),    32'(0));
   endtask

   initial begin
      logic [1:0] order [4];
      int exp_g;
      order = '{2'b01, 2'b10, 2'b01, 2'b10};
      rst_n     = 1'b0;
      req_valid = 2'b11;
      rsp_ready = '0;
      for (int i = 0; i < N; i++) begin a_v[i] = 8'd0; b_v[i] = 8'd0; op_v[i] = 6'd0; end
      drive_ops();
      #1;
      check_all_zero("reset");
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      mptr  = 0;

      // Fairness from reset: both requesters keep valid high.
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < N; i++) begin
            a_v[i] = 8'($urandom); b_v[i] = 8'($urandom); op_v[i] = 6'd9;
         end
         do_round(2'b11, 0, 1'b1, g);
         check("rr_order", 32'(g), 32'(order[t]));
      end
      req_valid = '0;

      a_v[0] = 8'd100; b_v[0] = 8'd27; op_v[0] = 6'd0;
      do_round(2'b01, 0, 1'b0, g);

      a_v[1] = 8'd200; b_v[1] = 8'd7; op_v[1] = 6'd3;
      do_round(2'b10, 0, 1'b0, g);
      check("div_grant", 32'(g), 32'(2'b10));

      // Backpressure on req0 while req1 waits.
      a_v[0] = 8'd40; b_v[0] = 8'd2; op_v[0] = 6'd1;
      a_v[1] = 8'd6;  b_v[1] = 8'd7; op_v[1] = 6'd2;
      do_round(2'b11, 5, 1'b0, g);
      check("bp_next_grant", 32'(req_ready), 32'(2'b10));
      do_round(2'b10, 0, 1'b0, g);

      a_v[0] = 8'd5; b_v[0] = 8'd3; op_v[0] = 6'b010000;
      do_round(2'b01, 0, 1'b0, g);

      // Valid withdrawn before the edge: no grant, pointer unchanged.
      req_valid = 2'b11;
      #1;
      exp_g = pick(2'b11);
      check("drop_ready", 32'(req_ready), 32'(1) << exp_g);
      #1;
      req_valid = '0;
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      check("drop_ready_again", 32'(req_ready), 32'(1) << exp_g);
      check("drop_no_rsp", 32'(rsp_valid), 32'(0));
      req_valid = '0;
      @(negedge clk);

      // Reset in the second EXEC cycle of a multiply.
      a_v[0] = 8'd9; b_v[0] = 8'd7; op_v[0] = 6'd2;
      drive_ops();
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      check("mid_mul_op", 32'(alu_op), 32'(6'd2));
      rst_n     = 1'b0;
      req_valid = 2'b11;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      mptr  = 0;
      for (int i = 0; i < N; i++) begin a_v[i] = 8'd1; b_v[i] = 8'd1; op_v[i] = 6'd0; end
      do_round(2'b11, 0, 1'b0, g);
      check("post_reset_grant", 32'(g), 32'(2'b01));

      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < N; i++) begin
            a_v[i] = 8'($urandom); b_v[i] = 8'($urandom); op_v[i] = rand_op();
         end
         do_round(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b0, g);
      end
      req_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
